// File: rtl/wheel_brake.sv
// Ring-position spinner that, on a stop request, brakes through a random number
// of extra steps with a growing tick period, then pulses landed_o once.
module wheel_brake #(
  parameter int NUM_POS   = 8,
  parameter int POS_W     = 3,
  parameter int RAND_W    = 4,
  parameter int MIN_EXTRA = 4,
  parameter int MAX_DIV   = 8,
  parameter int DIV_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              stop_i,
  input  logic              dir_i,
  input  logic [RAND_W-1:0] rand_i,
  output logic [POS_W-1:0]  pos_o,
  output logic              running_o,
  output logic              braking_o,
  output logic              landed_o
);

  localparam int SL_MAX = MIN_EXTRA + (1 << RAND_W) - 1;
  localparam int SL_W   = $clog2(SL_MAX + 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(MAX_DIV);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BRAKE   = 2'd1,
    ST_STOPPED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [SL_W-1:0]   steps_left_q, steps_left_d;
  logic [DIV_W-1:0]  period_q, period_d;
  logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic              running_q, running_d;
  logic              braking_q, braking_d;
  logic              landed_q, landed_d;

  // Wrapping step around a ring whose size need not be a power of two.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic up);
    logic [POS_W-1:0] r;
    if (up) begin
      if (p == LAST_POS) r = '0;
      else               r = p + POS_W'(1);
    end else begin
      if (p == '0) r = LAST_POS;
      else         r = p - POS_W'(1);
    end
    return r;
  endfunction

  // Next-state, position and braking-schedule logic.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    steps_left_d = steps_left_q;
    period_d     = period_q;
    tick_cnt_d   = tick_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (tick_i) pos_d = step_pos(pos_q, dir_i);
        else        pos_d = pos_q;
        if (stop_i) begin
          state_d      = ST_BRAKE;
          steps_left_d = SL_W'(MIN_EXTRA) + SL_W'(rand_i);
          period_d     = DIV_W'(1);
          tick_cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_BRAKE: begin
        if (tick_i) begin
          if (tick_cnt_q == period_q - DIV_W'(1)) begin
            pos_d        = step_pos(pos_q, dir_i);
            steps_left_d = steps_left_q - SL_W'(1);
            tick_cnt_d   = '0;
            if (period_q >= DIV_MAX) period_d = DIV_MAX;
            else                     period_d = period_q + DIV_W'(1);
            if (steps_left_q == SL_W'(1)) state_d = ST_STOPPED;
            else                          state_d = ST_BRAKE;
          end else begin
            tick_cnt_d = tick_cnt_q + DIV_W'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_STOPPED: begin
        if (stop_i) state_d = ST_STOPPED;
        else        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Outputs are registered copies of what the next state decodes to.
    running_d = (state_d != ST_STOPPED);
    braking_d = (state_d == ST_BRAKE);
    landed_d  = (state_q == ST_BRAKE) && (state_d == ST_STOPPED);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      pos_q        <= '0;
      steps_left_q <= '0;
      period_q     <= '0;
      tick_cnt_q   <= '0;
      running_q    <= 1'b1;
      braking_q    <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      steps_left_q <= steps_left_d;
      period_q     <= period_d;
      tick_cnt_q   <= tick_cnt_d;
      running_q    <= running_d;
      braking_q    <= braking_d;
      landed_q     <= landed_d;
    end
  end

  assign pos_o     = pos_q;
  assign running_o = running_q;
  assign braking_o = braking_q;
  assign landed_o  = landed_q;

endmodule

// File: tb/tb_wheel_brake.sv
// Bench for wheel_brake: directed scenarios plus random traffic against a
// queue-based model of the braking schedule; second instance uses a 10-position ring.
module tb_wheel_brake;

  localparam int N1 = 8;
  localparam int N2 = 10;
  localparam int MIN_EXTRA = 4;
  localparam int MAX_DIV = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst, tick, stop, dir;
  logic [3:0] rnd;
  logic [2:0] pos;
  logic       running, braking, landed;

  logic       tick2, dir2;
  logic [3:0] pos2;
  logic       running2, braking2, landed2;

  int errors = 0;
  int checks = 0;

  // behavioural model state: 0 = RUN, 1 = BRAKE, 2 = STOPPED
  int m_state, m_pos, m_landed, m2_pos;
  int q[$];

  wheel_brake dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .stop_i(stop), .dir_i(dir),
    .rand_i(rnd), .pos_o(pos), .running_o(running), .braking_o(braking), .landed_o(landed)
  );

  wheel_brake #(.NUM_POS(N2), .POS_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick2), .stop_i(1'b0), .dir_i(dir2),
    .rand_i(4'd0), .pos_o(pos2), .running_o(running2), .braking_o(braking2), .landed_o(landed2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ring_step(input int p, input int up, input int n);
    return up ? (p + 1) % n : (p + n - 1) % n;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_landed = 0; m2_pos = 0;
    q.delete();
  endtask

  task automatic model_edge();
    m_landed = 0;
    if (tick2) m2_pos = ring_step(m2_pos, int'(dir2), N2);
    case (m_state)
      0: begin
        if (tick) m_pos = ring_step(m_pos, int'(dir), N1);
        if (stop) begin
          q.delete();
          for (int k = 1; k <= MIN_EXTRA + int'(rnd); k++)
            q.push_back(k < MAX_DIV ? k : MAX_DIV);
          m_state = 1;
        end
      end
      1: begin
        if (tick) begin
          q[0] = q[0] - 1;
          if (q[0] == 0) begin
            void'(q.pop_front());
            m_pos = ring_step(m_pos, int'(dir), N1);
            if (q.size() == 0) begin
              m_state = 2;
              m_landed = 1;
            end
          end
        end
      end
      default: if (!stop) m_state = 0;
    endcase
  endtask

  task automatic check_all();
    chk("pos", 32'(pos), 32'(m_pos));
    chk("running", 32'(running), 32'(m_state != 2));
    chk("braking", 32'(braking), 32'(m_state == 1));
    chk("landed", 32'(landed), 32'(m_landed));
    chk("pos2", 32'(pos2), 32'(m2_pos));
  endtask

  task automatic cyc(input logic t, input logic s, input logic d, input logic [3:0] r);
    tick = t; stop = s; dir = d; rnd = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (int'(pos2) >= N2) chk("pos2_range", 32'(pos2), 32'(N2 - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // run a brake to completion counting ticks; returns tick count and step tick indices
  task automatic run_brake(input int drop_after, output int ticks, output int step_at[$]);
    int prev;
    ticks = 0;
    step_at.delete();
    for (int i = 0; i < 400; i++) begin
      prev = int'(pos);
      cyc(1'b1, (ticks < drop_after) ? 1'b1 : 1'b0, 1'b1, 4'd0);
      ticks++;
      if (int'(pos) != prev) step_at.push_back(ticks);
      if (landed) break;
    end
  endtask

  initial begin
    int ticks;
    int step_at[$];
    int exp_steps[7] = '{1, 3, 6, 10, 15, 21, 28};
    tick = 0; stop = 0; dir = 1; rnd = 0; tick2 = 0; dir2 = 1;
    do_reset();

    // plain spinning with wrap in both directions
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 4'd0);
    chk("run_up_pos", 32'(pos), 32'd2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("run_down_wrap", 32'(pos), 32'd7);

    // 10-position ring
    do_reset();
    tick2 = 1; dir2 = 1;
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("ring10_up", 32'(pos2), 32'd2);
    dir2 = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("ring10_wrap", 32'(pos2), 32'd9);
    tick2 = 0;

    // brake from 5 with rand 3: 7 steps at cumulative ticks 1,3,6,10,15,21,28
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 4'd3);
    chk("brake_entry", 32'(braking), 32'd1);
    run_brake(1000, ticks, step_at);
    chk("brake_ticks_r3", 32'(ticks), 32'd28);
    chk("brake_nsteps_r3", 32'(step_at.size()), 32'd7);
    for (int i = 0; i < 7 && i < step_at.size(); i++) chk("brake_step_tick", 32'(step_at[i]), 32'(exp_steps[i]));
    chk("brake_final_pos", 32'(pos), 32'd4);
    chk("landed_pulse", 32'(landed), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 4'd0);
    chk("stopped_running", 32'(running), 32'd0);
    chk("landed_one_cycle", 32'(landed), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'd0);
    chk("resume_step", 32'(pos), 32'd5);

    // stop dropped after 2 ticks: braking still completes, STOPPED lasts 1 cycle
    cyc(1'b0, 1'b1, 1'b1, 4'd0);
    run_brake(2, ticks, step_at);
    chk("drop_ticks", 32'(ticks), 32'd10);
    chk("drop_landed", 32'(landed), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 4'd0);
    chk("drop_back_to_run", 32'(running), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 4'd0);

    // maximum brake: 19 steps over 124 ticks
    cyc(1'b0, 1'b1, 1'b1, 4'd15);
    run_brake(1000, ticks, step_at);
    chk("brake_ticks_r15", 32'(ticks), 32'd124);
    chk("brake_nsteps_r15", 32'(step_at.size()), 32'd19);

    // asynchronous reset mid-brake
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    chk("async_pos", 32'(pos), 32'd0);
    chk("async_running", 32'(running), 32'd1);
    chk("async_braking", 32'(braking), 32'd0);
    chk("async_landed", 32'(landed), 32'd0);
    #3;
    rst = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick2 = 1'($urandom_range(0, 1));
      dir2  = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
